// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmit-engine-side signals shared by the
// UART transmit arbiter and whatever drives it.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic           err_timeout;
  logic           active;

  modport master (
    output req, req_last, req_data, tx_busy,
    input  ack, grant, tx_data, tx_start, err_timeout, active
  );

  modport slave (
    input  req, req_last, req_data, tx_busy,
    output ack, grant, tx_data, tx_start, err_timeout, active
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one UART transmit engine from N byte streams,
// keeping multi-byte packets together up to a burst limit.
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 16,
  parameter int IDLE_GAP  = 0,
  parameter int BUSY_WAIT = 4
) (
  input logic            clk,
  input logic            rst,
  uart_tx_arbiter_if.slave arb
);

  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int SW    = PW + 1;
  localparam int BW    = $clog2(MAX_BURST + 1);
  localparam int CMAX  = (BUSY_WAIT > IDLE_GAP) ? BUSY_WAIT : IDLE_GAP;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [SW-1:0] N_W       = SW'(N);
  localparam logic [PW-1:0] PTR_INIT  = PW'(N - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_WAIT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t        state_q;
  logic [PW-1:0] ptr_q;
  logic          lock_q;
  logic [BW-1:0] burst_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  ack_q;
  logic [N-1:0]  grant_q;
  logic [7:0]    tx_data_q;
  logic          tx_start_q;
  logic          err_q;
  logic          active_q;

  logic          lock_hold;
  logic          win_valid;
  logic [PW-1:0] win_idx;
  logic [N-1:0]  win_oh_d;
  logic [BW-1:0] burst_d;
  logic [SW-1:0] scan_sum;

  // Owner keeps priority only while its packet is live and under the burst
  // limit; otherwise scan downward so the closest requester after ptr wins.
  always_comb begin
    lock_hold = lock_q && arb.req[ptr_q] && (burst_q < BURST_MAX);
    win_valid = 1'b0;
    win_idx   = ptr_q;
    scan_sum  = '0;
    if (lock_hold) begin
      win_valid = 1'b1;
    end else begin
      for (int off = N; off >= 1; off--) begin
        scan_sum = {1'b0, ptr_q} + SW'(off);
        if (scan_sum >= N_W) scan_sum = scan_sum - N_W;
        if (arb.req[scan_sum[PW-1:0]]) begin
          win_valid = 1'b1;
          win_idx   = scan_sum[PW-1:0];
        end
      end
    end
    win_oh_d          = '0;
    win_oh_d[win_idx] = 1'b1;
    if (win_idx != ptr_q)        burst_d = BW'(1);
    else if (burst_q == BURST_MAX) burst_d = burst_q;
    else                         burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_INIT;
      lock_q     <= 1'b0;
      burst_q    <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      grant_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!lock_hold) begin
            lock_q  <= 1'b0;
            grant_q <= '0;
          end
          if (!arb.tx_busy && win_valid) begin
            tx_data_q  <= arb.req_data[{win_idx, 3'b000} +: 8];
            tx_start_q <= 1'b1;
            ack_q      <= win_oh_d;
            grant_q    <= win_oh_d;
            ptr_q      <= win_idx;
            lock_q     <= !arb.req_last[win_idx];
            burst_q    <= burst_d;
            cnt_q      <= '0;
            active_q   <= 1'b1;
            state_q    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (arb.tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == BUSY_LAST) begin
            // Engine never took the byte: drop it and free the line.
            err_q    <= 1'b1;
            lock_q   <= 1'b0;
            grant_q  <= '0;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!arb.tx_busy) begin
            cnt_q <= '0;
            if (IDLE_GAP > 0) begin
              state_q <= GAP;
            end else begin
              active_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            active_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign arb.ack         = ack_q;
  assign arb.grant       = grant_q;
  assign arb.tx_data     = tx_data_q;
  assign arb.tx_start    = tx_start_q;
  assign arb.err_timeout = err_q;
  assign arb.active      = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte streams, a simple engine model,
// and a packet-level predictor of which byte goes on the line next.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int MAXB  = 4;
  localparam int GAPC  = 1;
  localparam int BWAIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus();

  uart_tx_arbiter #(
    .N(N), .MAX_BURST(MAXB), .IDLE_GAP(GAPC), .BUSY_WAIT(BWAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(bus)
  );

  int vectors;
  int miscompares;

  logic [8:0] streamMem [N][32];
  int head [N];
  int len  [N];

  int         expIdx [$];
  logic [7:0] expData [$];
  int obsCount, tickNo, scenStart, firstLat, errTick;

  int mPtr, mBurst;
  bit mLock;

  bit engineOn, engBusy, engPend, lockWatch, enableOnErr;
  int engDly, engLeft, engMinLen, engMaxLen, engMaxDly;

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (head[i] < len[i]) begin
        bus.req[i]            = 1'b1;
        bus.req_last[i]       = streamMem[i][head[i]][8];
        bus.req_data[8*i +: 8] = streamMem[i][head[i]][7:0];
      end else begin
        bus.req[i]            = 1'b0;
        bus.req_last[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  task clearStreams();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      len[i]  = 0;
    end
  endtask

  task modelReset();
    mPtr   = N - 1;
    mBurst = 0;
    mLock  = 1'b0;
  endtask

  task loadByte(input int i, input logic [7:0] d, input bit last);
    streamMem[i][len[i]] = {last, d};
    len[i]++;
  endtask

  task loadPacket(input int i, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) loadByte(i, 8'(base + k), (k == n - 1));
  endtask

  // Predict the line order: a live packet under the burst limit keeps the
  // line, otherwise the next pending requester after the last owner gets it.
  task buildExpected();
    int  h [N];
    int  w;
    int  c;
    bit  found;
    expIdx.delete();
    expData.delete();
    for (int i = 0; i < N; i++) h[i] = head[i];
    while (1) begin
      found = 1'b0;
      w     = 0;
      if (mLock && h[mPtr] < len[mPtr] && mBurst < MAXB) begin
        w     = mPtr;
        found = 1'b1;
      end else begin
        mLock = 1'b0;
        for (int off = 1; off <= N; off++) begin
          c = (mPtr + off) % N;
          if (!found && h[c] < len[c]) begin
            w     = c;
            found = 1'b1;
          end
        end
      end
      if (!found) break;
      mBurst = (w != mPtr) ? 1 : ((mBurst < MAXB) ? mBurst + 1 : MAXB);
      mPtr   = w;
      mLock  = !streamMem[w][h[w]][8];
      expIdx.push_back(w);
      expData.push_back(streamMem[w][h[w]][7:0]);
      h[w]++;
    end
  endtask

  // One clock of bench activity at the falling edge: engine, monitor, drivers.
  task tick();
    @(negedge clk);
    tickNo++;
    if (rst) begin
      engBusy = 1'b0;
      engPend = 1'b0;
    end else begin
      if (engBusy) begin
        if (engLeft <= 1) engBusy = 1'b0;
        else engLeft--;
      end
      if (engPend) begin
        engDly--;
        if (engDly <= 0) begin
          engPend = 1'b0;
          engBusy = 1'b1;
          engLeft = $urandom_range(engMinLen, engMaxLen);
        end
      end
      if (bus.tx_start) begin
        if (firstLat < 0) firstLat = tickNo - scenStart;
        if (obsCount < expIdx.size()) begin
          checkOutput("ackOwner", bus.ack, 1 << expIdx[obsCount]);
          checkOutput("grantOwner", bus.grant, 1 << expIdx[obsCount]);
          checkOutput("txData", bus.tx_data, expData[obsCount]);
        end else begin
          checkOutput("extraStart", obsCount, expIdx.size());
        end
        obsCount++;
        if (engineOn) begin
          engDly = $urandom_range(0, engMaxDly);
          if (engDly == 0) begin
            engBusy = 1'b1;
            engLeft = $urandom_range(engMinLen, engMaxLen);
          end else begin
            engPend = 1'b1;
          end
        end
      end
      if (bus.err_timeout) begin
        if (errTick < 0) errTick = tickNo - scenStart;
        checkOutput("errIdle", bus.active, 0);
        if (enableOnErr) engineOn = 1'b1;
      end
      if (lockWatch && obsCount >= 1 && obsCount < 3) checkOutput("lockGrant", bus.grant, 1);
      for (int i = 0; i < N; i++) if (bus.ack[i] && head[i] < len[i]) head[i]++;
    end
    bus.tx_busy = engBusy;
    applyStimulus();
  endtask

  function automatic bit allConsumed();
    for (int i = 0; i < N; i++) if (head[i] < len[i]) return 1'b0;
    return 1'b1;
  endfunction

  task resetDut();
    rst = 1'b1;
    clearStreams();
    modelReset();
    engBusy     = 1'b0;
    engPend     = 1'b0;
    bus.tx_busy = 1'b0;
    applyStimulus();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task runScenario(input string name);
    bit done;
    buildExpected();
    obsCount  = 0;
    firstLat  = -1;
    errTick   = -1;
    scenStart = tickNo;
    done      = 1'b0;
    applyStimulus();
    for (int c = 0; c < 3000 && !done; c++) begin
      tick();
      if (allConsumed() && !bus.active && !bus.tx_busy && obsCount >= expIdx.size()) done = 1'b1;
    end
    checkOutput({name, ":finished"}, done, 1);
    repeat (3) tick();
    checkOutput({name, ":startCount"}, obsCount, expIdx.size());
    checkOutput({name, ":latency"}, firstLat, 1);
    checkOutput({name, ":grantIdle"}, bus.grant, 0);
    checkOutput({name, ":activeIdle"}, bus.active, 0);
  endtask

  task checkResetOutputs(input string name);
    checkOutput({name, ":ack"}, bus.ack, 0);
    checkOutput({name, ":grant"}, bus.grant, 0);
    checkOutput({name, ":txStart"}, bus.tx_start, 0);
    checkOutput({name, ":txData"}, bus.tx_data, 0);
    checkOutput({name, ":err"}, bus.err_timeout, 0);
    checkOutput({name, ":active"}, bus.active, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawBusy;
    vectors     = 0;
    miscompares = 0;
    tickNo      = 0;
    obsCount    = 0;
    firstLat    = -1;
    errTick     = -1;
    scenStart   = 0;
    lockWatch   = 1'b0;
    enableOnErr = 1'b0;
    engineOn    = 1'b1;
    engMinLen   = 3;
    engMaxLen   = 3;
    engMaxDly   = 0;
    engDly      = 0;
    engLeft     = 0;
    rst         = 1'b1;
    bus.tx_busy = 1'b0;
    clearStreams();
    modelReset();
    applyStimulus();
    #2;
    checkResetOutputs("reset");
    resetDut();

    $display("[TB] single byte from requester 2");
    resetDut();
    engMinLen = 20; engMaxLen = 20; engMaxDly = 0;
    loadByte(2, 8'h41, 1'b1);
    runScenario("single");

    $display("[TB] round-robin over all requesters");
    resetDut();
    engMinLen = 3; engMaxLen = 3; engMaxDly = 1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) loadByte(i, 8'(8'h10 + i), 1'b1);
    runScenario("roundRobin");

    $display("[TB] packet lock");
    resetDut();
    engMinLen = 1; engMaxLen = 5; engMaxDly = 2;
    loadPacket(0, 3, 8'h0a);
    loadByte(1, 8'h20, 1'b1);
    lockWatch = 1'b1;
    runScenario("packetLock");
    lockWatch = 1'b0;

    $display("[TB] burst limit");
    resetDut();
    loadPacket(0, 6, 8'h30);
    loadByte(3, 8'h3f, 1'b1);
    runScenario("burstLimit");

    $display("[TB] busy timeout");
    resetDut();
    engineOn    = 1'b0;
    enableOnErr = 1'b1;
    engMinLen = 4; engMaxLen = 4; engMaxDly = 0;
    loadByte(1, 8'h51, 1'b1);
    loadByte(2, 8'h52, 1'b1);
    runScenario("timeout");
    checkOutput("timeout:errDelay", errTick - firstLat, BWAIT);
    checkOutput("timeout:engineBack", engineOn, 1);
    enableOnErr = 1'b0;
    engineOn    = 1'b1;

    $display("[TB] reset during a frame");
    resetDut();
    engMinLen = 30; engMaxLen = 30; engMaxDly = 0;
    loadByte(0, 8'h77, 1'b1);
    buildExpected();
    obsCount  = 0;
    firstLat  = -1;
    errTick   = -1;
    scenStart = tickNo;
    sawBusy   = 1'b0;
    applyStimulus();
    for (int c = 0; c < 100 && !sawBusy; c++) begin
      tick();
      if (bus.tx_busy && obsCount == 1) sawBusy = 1'b1;
    end
    checkOutput("midFrame:busySeen", sawBusy, 1);
    repeat (3) tick();
    checkOutput("midFrame:active", bus.active, 1);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("midFrame");
    tick();
    rst = 1'b0;
    clearStreams();
    modelReset();
    engMinLen = 2; engMaxLen = 6; engMaxDly = 2;
    for (int i = 0; i < N; i++) loadByte(i, 8'(8'h60 + i), 1'b1);
    runScenario("afterReset");

    $display("[TB] randomized packet traffic");
    for (int r = 0; r < 6; r++) begin
      clearStreams();
      engMinLen = 1;
      engMaxLen = $urandom_range(1, 8);
      engMaxDly = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) loadPacket(i, $urandom_range(1, 6), 8'($urandom));
      end
      runScenario("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmit engine among N byte-stream requesters. It sits between client logic (command responders, debug printers) and the transmit engine. It picks one requester and hands its byte to the engine with a one-cycle start strobe. It then waits for the engine to finish the frame before serving anyone else. Multi-byte packets keep the grant until their last byte, bounded by a burst limit, so packets from different clients are not interleaved on the line.

## Interface
- N, 4, number of requesters (2..8)
- MAX_BURST, 16, max consecutive bytes one owner may send before forced re-arbitration (≥1)
- IDLE_GAP, 0, extra idle clk cycles inserted after each frame before next arbitration
- BUSY_WAIT, 4, clk cycles allowed for tx_busy to rise after tx_start
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N  per-requester byte valid; held with data until ack
- req_last  in  N  per-requester flag: current byte ends its packet
- req_data  in  8*N  byte of requester i on bits [8i+7:8i]
- ack  out  N  one-cycle pulse: byte of requester i accepted
- grant  out  N  one-hot current owner, 0 when none
- tx_data  out  8  byte to transmit engine, valid with tx_start
- tx_start  out  1  one-cycle pulse starting a frame
- tx_busy  in  1  engine busy, high from accept until stop bit finished
- err_timeout  out  1  one-cycle pulse: engine did not go busy within BUSY_WAIT
- active  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE, tx_busy=0 and candidate exists → next edge: tx_data←winner byte, tx_start=1, ack[winner]=1 (both single-cycle), grant←onehot(winner), ptr←winner, state→WAIT_BUSY.
- Candidate selection: if lock set, owner's req=1, and burst_cnt<MAX_BURST → owner wins. Otherwise round-robin: first i with req[i]=1, scanning ptr+1, ptr+2, … wrapping modulo N.
- Lock: on each accepted byte, lock←!req_last[winner]. burst_cnt←1 on owner change, else +1, saturating at MAX_BURST.
- Lock release: the lock is cleared when burst_cnt=MAX_BURST or the owner's req=0 in IDLE (abandoned packet). After release, selection is pure round-robin, so the old owner has lowest priority.
- IDLE, tx_busy=1: no grant.
- grant: held from accept until lock clears. Reads 0 in IDLE when unlocked.
- WAIT_BUSY: tx_busy=1 → WAIT_DONE. Otherwise count cycles. On BUSY_WAIT cycles without busy: err_timeout pulse, lock cleared, grant←0, state→IDLE. The byte is lost and ack is not retracted.
- WAIT_DONE: tx_busy=0 → GAP if IDLE_GAP>0, else IDLE.
- GAP: count IDLE_GAP cycles → IDLE.
- req changes in non-IDLE states are ignored. Only the IDLE sample matters.
- Reset values: state=IDLE, ptr=N-1 (requester 0 first), lock=0, burst_cnt=0, ack=0, grant=0, tx_start=0, tx_data=8'h00, err_timeout=0, active=0. Reset mid-frame aborts immediately. No pulse is emitted on reset exit.

## Timing
- req sampled in IDLE at edge k → tx_start/ack high during cycle k+1 (1-cycle latency, registered outputs).
- Requester may present its next byte from cycle k+2. The arbiter is then out of IDLE and cannot double-accept.
- Minimum byte-to-byte spacing: engine busy time + 1 (WAIT_DONE→IDLE) + IDLE_GAP + 1 (IDLE sample) cycles.
- Simultaneous req from all N, unlocked: grants in order ptr+1 … wrapping. Each requester is served once per N frames.
- tx_busy falling and a new req in the same cycle: the new req is evaluated in the next IDLE cycle, never in WAIT_DONE.

## Test plan
- Single byte: req[2]=1, data=8'h41, last=1, engine busy 20 cycles → one tx_start with tx_data=41, ack[2] one cycle later than req sample, grant=0 after frame, active low.
- Round-robin: N=4, all req high, last=1, data=8'h10+i → tx_data sequence 10,11,12,13,10 from reset. Each ack fires once per round.
- Packet lock: req0 sends 3-byte packet (last on 3rd) while req1 is continuously requesting → bytes 0a,0b,0c then req1's byte. grant=0001 throughout the packet.
- Burst limit: MAX_BURST=4, req0 packet of 6 bytes, req3 pending → req0×4, req3×1, req0×2.
- Timeout: tx_busy tied 0 → err_timeout pulses BUSY_WAIT cycles after tx_start, state IDLE, next requester served normally.
- Reset mid-frame: assert rst during WAIT_DONE → all outputs at reset values asynchronously. After release, requester 0 wins a 4-way contention.
